// File: rtl/rr_output_arbiter_pkg.sv
// rtl/rr_output_arbiter_pkg.sv - shared router constants and packet type for the output arbiter
package rr_output_arbiter_pkg;

    // Router geometry
    localparam int ARB_N             = 5;
    localparam int ARB_BURST         = 4;
    localparam int INPUT_QUEUE_DEPTH = 4;

    // Input port indices, in request-vector order
    localparam int PORT_NORTH = 0;
    localparam int PORT_EAST  = 1;
    localparam int PORT_SOUTH = 2;
    localparam int PORT_WEST  = 3;
    localparam int PORT_LOCAL = 4;

    // Packet carried through the router
    typedef struct packed {
        logic [2:0] src;
        logic [2:0] dest;
        logic [9:0] payload;
    } packet_t;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational rotating-priority encoder starting at ptr
module rr_priority_pick
    import rr_output_arbiter_pkg::*;
#(
    parameter int N  = ARB_N,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any,
    output logic [PW-1:0] idx
);

    logic [PW-1:0] cand;

    // Walk N positions from ptr, wrapping at N-1 explicitly; first requester wins
    always_comb begin
        gnt  = '0;
        any  = 1'b0;
        idx  = '0;
        cand = ptr;
        for (int k = 0; k < N; k++) begin
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
            cand = (cand == PW'(N - 1)) ? '0 : cand + 1'b1;
        end
    end

endmodule

// File: rtl/rr_output_arbiter.sv
// rtl/rr_output_arbiter.sv - round-robin output port arbiter with one-entry output register; optional burst mode via ARB_BURST_EN
module rr_output_arbiter
    import rr_output_arbiter_pkg::*;
#(
    parameter int N     = ARB_N,
    parameter int BURST = ARB_BURST
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  packet_t [N-1:0]   i_data,
    input  logic [N-1:0]      i_data_val,
    output logic [N-1:0]      o_en,
    output packet_t           o_data,
    output logic              o_data_val,
    input  logic              i_en,
    output logic [N-1:0]      o_grant
);

    localparam int PW = $clog2(N);

    if (BURST < 1) begin : g_bad_burst
        $error("rr_output_arbiter: BURST must be at least 1");
    end

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] gnt_idx;
    logic [N-1:0]  pick_gnt;
    logic [N-1:0]  gnt;
    logic          pick_any;
    logic          slot_free;
    logic          take;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        return (v == PW'(N - 1)) ? '0 : v + 1'b1;
    endfunction

    rr_priority_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req (i_data_val),
        .ptr (ptr),
        .gnt (pick_gnt),
        .any (pick_any),
        .idx (pick_idx)
    );

`ifdef ARB_BURST_EN
    localparam int BW = $clog2(BURST + 1);

    logic [BW-1:0] bcnt;
    logic [BW-1:0] bcnt_next;
    logic          burst_hold;

    // During a burst ptr sits on the current grantee, so it doubles as the burst owner
    assign burst_hold = (bcnt != '0) && (bcnt < BW'(BURST)) && i_data_val[ptr];

    // Burst override on top of the rotating pick; ptr advances once the burst is spent
    always_comb begin
        if (burst_hold) begin
            gnt       = '0;
            gnt[ptr]  = 1'b1;
            gnt_idx   = ptr;
            bcnt_next = bcnt + 1'b1;
        end else begin
            gnt       = pick_gnt;
            gnt_idx   = pick_idx;
            bcnt_next = BW'(1);
        end
        ptr_next = (bcnt_next == BW'(BURST)) ? wrap_inc(gnt_idx) : gnt_idx;
    end

    // Consecutive-grant counter for the current owner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcnt <= '0;
        end else if (take) begin
            bcnt <= bcnt_next;
        end
    end
`else
    assign gnt      = pick_gnt;
    assign gnt_idx  = pick_idx;
    assign ptr_next = wrap_inc(pick_idx);
`endif

    assign slot_free = ~o_data_val | i_en;
    assign take      = reset_n & ce & slot_free & pick_any;
    assign o_en      = take ? gnt : '0;

    // Output register: load on grant, drain when the slot frees with nothing to load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_data     <= '0;
            o_data_val <= 1'b0;
            o_grant    <= '0;
            ptr        <= '0;
        end else if (ce) begin
            if (take) begin
                o_data     <= i_data[gnt_idx];
                o_data_val <= 1'b1;
                o_grant    <= gnt;
                ptr        <= ptr_next;
            end else if (slot_free) begin
                o_data_val <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_output_arbiter.sv
// tb/tb_rr_output_arbiter.sv - self-checking bench for rr_output_arbiter
`timescale 1ns/1ps
module tb_rr_output_arbiter;
    import rr_output_arbiter_pkg::*;

    localparam int N     = ARB_N;
    localparam int BURST = ARB_BURST;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            ce;
    logic            i_en;
    packet_t [N-1:0] i_data;
    logic [N-1:0]    i_data_val;
    logic [N-1:0]    o_en;
    packet_t         o_data;
    logic            o_data_val;
    logic [N-1:0]    o_grant;

    always #5 clk = ~clk;

    rr_output_arbiter #(.N(N), .BURST(BURST)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .i_data     (i_data),
        .i_data_val (i_data_val),
        .o_en       (o_en),
        .o_data     (o_data),
        .o_data_val (o_data_val),
        .i_en       (i_en),
        .o_grant    (o_grant)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state (current) and prediction for the next edge
    packet_t      m_data  = '0;
    logic         m_val   = 1'b0;
    logic [N-1:0] m_grant = '0;
    int           m_ptr   = 0;
    int           m_bcnt  = 0;
    packet_t      x_data  = '0;
    logic         x_val   = 1'b0;
    logic [N-1:0] x_grant = '0;
    int           x_ptr   = 0;
    int           x_bcnt  = 0;

    logic [N-1:0] popped = '0;
    int           pop_count = 0;
    int           glog[$];
    int           seq[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model mid-cycle and predict the next edge
    always @(negedge clk) begin
        logic [N-1:0] e_en;
        int g;
        int held;
        e_en = '0;
        g    = -1;
        held = 0;
        if (!reset_n) begin
            check("rst_en",    o_en,       '0);
            check("rst_val",   o_data_val, 1'b0);
            check("rst_data",  o_data,     '0);
            check("rst_grant", o_grant,    '0);
            x_data = '0; x_val = 1'b0; x_grant = '0; x_ptr = 0; x_bcnt = 0;
        end else begin
            x_data = m_data; x_val = m_val; x_grant = m_grant; x_ptr = m_ptr; x_bcnt = m_bcnt;
            if (ce && (!m_val || i_en)) begin
`ifdef ARB_BURST_EN
                if (m_bcnt > 0 && m_bcnt < BURST && i_data_val[m_ptr]) begin
                    g    = m_ptr;
                    held = 1;
                end
`endif
                if (held == 0) begin
                    for (int k = 0; k < N; k++)
                        if (g < 0 && i_data_val[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
                if (g >= 0) begin
                    e_en[g] = 1'b1;
                    x_data  = i_data[g];
                    x_val   = 1'b1;
                    x_grant = e_en;
                    x_bcnt  = (held != 0) ? m_bcnt + 1 : 1;
`ifdef ARB_BURST_EN
                    x_ptr   = (x_bcnt == BURST) ? (g + 1) % N : g;
`else
                    x_ptr   = (g + 1) % N;
`endif
                end else begin
                    x_val = 1'b0;
                end
            end
            check("o_en",       o_en,       e_en);
            check("o_data_val", o_data_val, m_val);
            check("o_data",     o_data,     m_data);
            check("o_grant",    o_grant,    m_grant);
        end
        popped    = o_en;
        pop_count = pop_count + $countones(o_en);
        for (int k = 0; k < N; k++)
            if (o_en[k]) glog.push_back(k);
    end

    // Commit the prediction at the clock edge
    always @(posedge clk) begin
        if (!reset_n) begin
            m_data = '0; m_val = 1'b0; m_grant = '0; m_ptr = 0; m_bcnt = 0;
        end else begin
            m_data = x_data; m_val = x_val; m_grant = x_grant; m_ptr = x_ptr; m_bcnt = x_bcnt;
        end
    end

    task automatic drive_data();
        for (int j = 0; j < N; j++) begin
            i_data[j].src     = 3'(j);
            i_data[j].dest    = 3'(PORT_LOCAL);
            i_data[j].payload = 10'(seq[j]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int j = 0; j < N; j++)
            if (popped[j]) seq[j]++;
        drive_data();
    endtask

    task automatic check_glog(input string name, input int exp[]);
        check({name, "_len"}, glog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < glog.size(); i++)
            check(name, glog[i], exp[i]);
    endtask

    int s0;
    int pc0;

    initial begin
        reset_n    = 1'b0;
        ce         = 1'b1;
        i_en       = 1'b1;
        i_data_val = '0;
        for (int j = 0; j < N; j++) seq[j] = 16 * j;
        drive_data();
        repeat (3) step();

        // Reset values
        check("init_data",  o_data,     '0);
        check("init_val",   o_data_val, 1'b0);
        check("init_grant", o_grant,    '0);
        check("init_en",    o_en,       '0);

        // Release with everyone requesting: strict rotation
        i_data_val = '1;
        glog.delete();
        reset_n = 1'b1;
        repeat (6) step();
        check_glog("rot_after_reset", '{0, 1, 2, 3, 4, 0});

        // Reset mid-stream clears outputs immediately and restarts at 0
        repeat (2) step();
        reset_n = 1'b0;
        #1;
        check("midrst_en",    o_en,       '0);
        check("midrst_val",   o_data_val, 1'b0);
        check("midrst_grant", o_grant,    '0);
        check("midrst_data",  o_data,     '0);
        step();
        glog.delete();
        reset_n = 1'b1;
        step();
        check_glog("restart", '{0});

        // Single requester on input 3 wins every cycle
        i_data_val = 5'b01000;
        s0 = seq[3];
        glog.delete();
        repeat (6) step();
        check_glog("single", '{3, 3, 3, 3, 3, 3});
        check("single_payload", o_data.payload, 10'(s0 + 5));
        check("single_src",     o_data.src,     3'd3);
        check("single_val",     o_data_val,     1'b1);

        // Wrap and skip from ptr=4 with inputs 1 and 4
        i_data_val = 5'b10010;
        step();
        check("wrap_g0", o_grant, 5'b10000);
        step();
        check("wrap_g1", o_grant, 5'b00010);
        step();
        check("wrap_g2", o_grant, 5'b10000);

        // Drain, then stall downstream with all inputs valid
        i_data_val = '0;
        step();
        check("drain_val", o_data_val, 1'b0);
        i_data_val = '1;
        i_en = 1'b0;
        pc0 = pop_count;
        repeat (5) step();
        check("stall_pops",  pop_count - pc0, 1);
        check("stall_val",   o_data_val, 1'b1);
        check("stall_grant", o_grant, 5'b00001);
        check("stall_en",    o_en, '0);
        i_en = 1'b1;
        glog.delete();
        step();
        check_glog("stall_resume", '{1});

        // Clock enable low freezes everything
        ce = 1'b0;
        pc0 = pop_count;
        repeat (3) step();
        check("ce_pops",  pop_count - pc0, 0);
        check("ce_grant", o_grant, 5'b00010);
        check("ce_val",   o_data_val, 1'b1);
        ce = 1'b1;
        glog.delete();
        step();
        check_glog("ce_resume", '{2});

`ifdef ARB_BURST_EN
        // Bursts of BURST grants between inputs 0 and 2
        reset_n = 1'b0;
        step();
        i_data_val = 5'b00101;
        glog.delete();
        reset_n = 1'b1;
        repeat (9) step();
        check_glog("burst", '{0, 0, 0, 0, 2, 2, 2, 2, 0});

        // Input 0 drops mid-burst: the next grant moves on to 2
        reset_n = 1'b0;
        step();
        glog.delete();
        reset_n = 1'b1;
        repeat (2) step();
        i_data_val = 5'b00100;
        step();
        check_glog("burst_drop", '{0, 0, 2});
`endif

        i_data_val = '0;
        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_output_arbiter.md
# rr_output_arbiter

- Round-robin arbiter that shares one router output port among `N` input queues (`fifo_packet` instances).
- Picks one valid head-of-queue packet per cycle and pops it through the queue's read enable.
- Holds the packet in a one-entry output register, with a valid/enable handshake toward the downstream node.
- Sits between the input queues and the output link of each router port; one instance per output port.

## Interface

Parameters:
- `N`, 5, number of requesting input queues (N, E, S, W, local)
- `BURST`, 4, maximum consecutive grants to one input (only with `ARB_BURST_EN`); must be ≥1

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  reset; one clock, reset is asynchronous and active-low
- `ce`  in  1  clock enable; no state changes when low
- `i_data`  in  `N` × `packet_t`  head packet of each input queue
- `i_data_val`  in  `N`  head packet valid per queue (queue `o_data_val`)
- `o_en`  out  `N`  one-hot pop to the granted queue (drives queue `i_en`); combinational
- `o_data`  out  `packet_t`  registered output packet
- `o_data_val`  out  1  `o_data` valid; held until accepted
- `i_en`  in  1  downstream accepts `o_data` this cycle (downstream `o_en`, i.e. not full)
- `o_grant`  out  `N`  one-hot index of last granted input, registered (debug/stats)

## Operation

- Output slot is free when `~o_data_val | i_en`.
- Selection: when `ce` and the slot is free and any `i_data_val` is high, grant the first requester found scanning upward from `ptr` with wrap-around `N-1 → 0`.
- On a grant `g`:
  - `o_en[g]=1` in the same cycle.
  - At the edge: `o_data <= i_data[g]`, `o_data_val <= 1`, `o_grant <= onehot(g)`, `ptr <= (g+1) mod N`.
- Slot free, no requester: `o_data_val <= 0`; `o_data` and `o_grant` hold.
- Slot not free (`o_data_val & ~i_en`): `o_en` all zero; all registers hold.
- `ce` low: `o_en` all zero; all registers hold, regardless of `i_en`.
- `o_en` is one-hot or zero, never multi-hot. An input is never popped while its `i_data_val` is low.
- `ptr` is `$clog2(N)` bits. Wrap is an explicit compare with `N-1`, not power-of-two truncation.
- Reset mid-operation: the held packet is dropped; the input queue it came from has already been popped.
- Reset values: `o_data=0`, `o_data_val=0`, `o_grant=0`, `o_en=0`, `ptr=0`, burst count 0.

## Timing

- Latency: queue head to `o_data` is 1 cycle (captured at the grant edge).
- Throughput: 1 packet/cycle sustained while `i_en` stays high.
- Back-to-back: when `i_en` is high with `o_data_val`, the new grant loads in the same edge the old packet leaves. No bubble.
- Combinational paths:
  - `o_en` depends on `i_data_val`, `i_en`, `o_data_val`, `ce`, `ptr` and the burst state.
  - No combinational path from `i_data` to any output.
- All state updates on `posedge clk`; reset is sampled asynchronously on `negedge reset_n`.

## Configuration

- Macro `ARB_BURST_EN`.
- Defined:
  - A counter `bcnt` (`$clog2(BURST+1)` bits) counts consecutive grants to the last grantee.
  - If the last grantee `g` still has `i_data_val[g]` and `bcnt < BURST`, `g` wins again and `bcnt` increments.
  - `ptr` stays at `g` during the burst and becomes `(g+1) mod N` when `bcnt` reaches `BURST` or `g` drops valid. `bcnt` then restarts at 1 for the new grantee.
  - With `BURST=1`, behaviour is identical to undefined.
- Undefined: plain round-robin, one packet per grant; `bcnt` and the `BURST` parameter logic are absent.

## Structure

- `packet_t` comes from the shared `config.sv` definitions.
- Default `N` and `BURST`, and the port-index constants (N/E/S/W/local), go in the shared package, next to `INPUT_QUEUE_DEPTH`.
- One sub-module: `rr_priority_pick`.
  - Purely combinational rotating-priority encoder.
  - Inputs: `req[N]`, `ptr`. Outputs: one-hot `gnt[N]`, `any`, binary `idx`.
  - The burst override is applied outside it, in the arbiter.

## Test plan

- **Reset:** assert `reset_n=0` mid-stream → all outputs 0 immediately; after release with all `i_data_val=1` and `i_en=1`, grants run 0,1,2,3,4,0 on consecutive cycles.
- **Single requester:** only input 3 valid, `i_en=1` → `o_en[3]=1` every cycle; `o_data` equals input 3's sequence with 1-cycle latency; `o_data_val` stays high.
- **Downstream stall:** `i_en=0` for 5 cycles with all inputs valid → exactly one pop, then `o_en=0` and `o_data`/`o_data_val` held; on `i_en=1` the next grant goes to the `ptr` successor.
- **Wrap and skip:** `ptr=4`, inputs 1 and 4 valid → grant 4, then 1, then 4; `ptr` values 0, 2, 0.
- **ce gating:** `ce=0` for 3 cycles with requests pending → `o_en=0` and no register change; the resumed grant equals the one that would have occurred.
- **`ARB_BURST_EN`, BURST=4:** inputs 0 and 2 continuously valid → grants 0,0,0,0,2,2,2,2,0; drop input 0 after 2 grants → next grant is 2.
